mod_counter_nb: RTL and testbench

Parametrised N-bit counter that replaces the fixed 3-bit free-running counter used in the top-level wrapper.
- Adds programmable modulus, a prescaler, up/down direction, parallel load and synchronous clear.
- Supports three run modes: wrap, saturate, one-shot.
- Emits a registered terminal-count pulse, so it also serves as the baud/bit-tick source for the UART TX/RX path.

---
 rtl/counter_pkg.sv | 28 ++
 rtl/mod_prescaler.sv | 37 +++
 rtl/mod_counter_nb.sv | 142 ++++++++++++++
 tb/tb_mod_counter_nb.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the programmable counter: run-mode encodings,
// one-shot FSM states and a width helper for the prescaler.
package counter_pkg;

   localparam logic [1:0] MODE_WRAP    = 2'b00;
   localparam logic [1:0] MODE_SAT     = 2'b01;
   localparam logic [1:0] MODE_ONESHOT = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } os_state_t;

   // Bits needed to hold 0..value-1.
   function automatic int clog2(input int value);
      int res;
      int v;
      res = 0;
      v   = value - 1;
      while (v > 0) begin
         res++;
         v = v >> 1;
      end
      return res;
   endfunction

endpackage

// File: rtl/mod_prescaler.sv
// Divides enabled cycles by PRESCALE and emits a one-cycle step strobe.
// With PRESCALE=1 the counter stays at zero and step simply follows en.
module mod_prescaler
   import counter_pkg::*;
#(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ena,
   input  logic en,
   input  logic sync_clr,
   output logic step
);

   localparam int PW = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);
   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] cnt;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (ena) begin
         if (sync_clr || (en && (cnt == LAST))) begin
            cnt <= '0;
         end else if (en) begin
            cnt <= cnt + PW'(1);
         end
      end
   end

   assign step = en && (cnt == LAST);

endmodule

// File: rtl/mod_counter_nb.sv
// Parametrised up/down counter with modulus, prescaler, load, clear and
// wrap / saturate / one-shot run modes; tc is a registered one-cycle pulse.
module mod_counter_nb
   import counter_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int MODULUS  = 2 ** WIDTH,
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             en,
   input  logic             up_dn,
   input  logic [1:0]       mode,
   input  logic             start,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             clr,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             at_term,
   output logic             busy
);

   localparam logic [WIDTH:0]   MAX_EXT = (WIDTH + 1)'(MODULUS - 1);
   localparam logic [WIDTH-1:0] MAX     = MAX_EXT[WIDTH-1:0];

   os_state_t        state;
   os_state_t        state_nx;
   logic             step;
   logic             os_start;
   logic             sync_clr;
   logic [WIDTH:0]   cnt_ext;
   logic [WIDTH:0]   term_ext;
   logic [WIDTH:0]   moved;
   logic             moved_hits;
   logic [WIDTH-1:0] load_clamped;
   logic [WIDTH-1:0] count_nx;
   logic             tc_nx;

   assign os_start = start && (mode == MODE_ONESHOT);
   assign sync_clr = clr || load || os_start;

   mod_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk      (clk),
      .rst_n    (rst_n),
      .ena      (ena),
      .en       (en),
      .sync_clr (sync_clr),
      .step     (step)
   );

   // Arithmetic one bit wider than count so neither the clamp nor the
   // candidate next value can alias back into range.
   always_comb begin
      cnt_ext      = {1'b0, count};
      term_ext     = up_dn ? MAX_EXT : '0;
      moved        = up_dn ? (cnt_ext + 1'b1) : (cnt_ext - 1'b1);
      moved_hits   = (moved == term_ext);
      load_clamped = ({1'b0, load_val} > MAX_EXT) ? MAX : load_val;
   end

   assign at_term = (cnt_ext == term_ext);

   // NOTE: every combinational output gets a default first, so no path
   // leaves a signal unassigned and no latch is inferred.
   always_comb begin
      count_nx = count;
      tc_nx    = 1'b0;
      if (clr) begin
         count_nx = '0;
      end else if (load) begin
         count_nx = load_clamped;
      end else if (os_start) begin
         count_nx = up_dn ? '0 : MAX;
      end else if (step) begin
         case (mode)
            MODE_SAT: begin
               if (!at_term) begin
                  count_nx = moved[WIDTH-1:0];
                  tc_nx    = moved_hits;
               end
            end
            MODE_ONESHOT: begin
               if ((state == ST_RUN) && !at_term) begin
                  count_nx = moved[WIDTH-1:0];
                  tc_nx    = moved_hits;
               end
            end
            default: begin
               if (at_term) begin
                  count_nx = up_dn ? '0 : MAX;
                  tc_nx    = 1'b1;
               end else begin
                  count_nx = moved[WIDTH-1:0];
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
         tc    <= 1'b0;
      end else if (ena) begin
         count <= count_nx;
         tc    <= tc_nx;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else if (ena) begin
         state <= state_nx;
      end
   end

   // A RUN that is already parked on terminal (e.g. after a load) also
   // retires to DONE so the FSM cannot stall in RUN.
   always_comb begin
      state_nx = state;
      if ((mode != MODE_ONESHOT) || clr) begin
         state_nx = ST_IDLE;
      end else if (load) begin
         state_nx = state;
      end else if (start) begin
         state_nx = ST_RUN;
      end else if ((state == ST_RUN) && step && (at_term || moved_hits)) begin
         state_nx = ST_DONE;
      end
   end

   always_comb begin
      busy = (state == ST_RUN) && (mode == MODE_ONESHOT);
   end

endmodule

// File: tb/tb_mod_counter_nb.sv
// Directed bench: four counter configurations (legacy 3-bit, mod-10 /3
// prescale, mod-10 saturate/priority, mod-5 one-shot) share one clock.
module tb_mod_counter_nb;

   logic clk;
   logic rst_n;
   logic d_rst_n;
   int   total;
   int   bad;

   logic       a_ena, a_en, a_up_dn, a_start, a_load, a_clr;
   logic [1:0] a_mode;
   logic [2:0] a_load_val, a_count;
   logic       a_tc, a_at_term, a_busy;

   logic       b_ena, b_en, b_up_dn, b_start, b_load, b_clr;
   logic [1:0] b_mode;
   logic [3:0] b_load_val, b_count;
   logic       b_tc, b_at_term, b_busy;

   logic       c_ena, c_en, c_up_dn, c_start, c_load, c_clr;
   logic [1:0] c_mode;
   logic [3:0] c_load_val, c_count;
   logic       c_tc, c_at_term, c_busy;

   logic       d_ena, d_en, d_up_dn, d_start, d_load, d_clr;
   logic [1:0] d_mode;
   logic [2:0] d_load_val, d_count;
   logic       d_tc, d_at_term, d_busy;

   mod_counter_nb #(.WIDTH(3), .MODULUS(8), .PRESCALE(1)) u_a (
      .clk(clk), .rst_n(rst_n), .ena(a_ena), .en(a_en), .up_dn(a_up_dn),
      .mode(a_mode), .start(a_start), .load(a_load), .load_val(a_load_val),
      .clr(a_clr), .count(a_count), .tc(a_tc), .at_term(a_at_term), .busy(a_busy));

   mod_counter_nb #(.WIDTH(4), .MODULUS(10), .PRESCALE(3)) u_b (
      .clk(clk), .rst_n(rst_n), .ena(b_ena), .en(b_en), .up_dn(b_up_dn),
      .mode(b_mode), .start(b_start), .load(b_load), .load_val(b_load_val),
      .clr(b_clr), .count(b_count), .tc(b_tc), .at_term(b_at_term), .busy(b_busy));

   mod_counter_nb #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) u_c (
      .clk(clk), .rst_n(rst_n), .ena(c_ena), .en(c_en), .up_dn(c_up_dn),
      .mode(c_mode), .start(c_start), .load(c_load), .load_val(c_load_val),
      .clr(c_clr), .count(c_count), .tc(c_tc), .at_term(c_at_term), .busy(c_busy));

   mod_counter_nb #(.WIDTH(3), .MODULUS(5), .PRESCALE(1)) u_d (
      .clk(clk), .rst_n(d_rst_n), .ena(d_ena), .en(d_en), .up_dn(d_up_dn),
      .mode(d_mode), .start(d_start), .load(d_load), .load_val(d_load_val),
      .clr(d_clr), .count(d_count), .tc(d_tc), .at_term(d_at_term), .busy(d_busy));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; d_rst_n = 1'b0;
      a_ena = 1'b0; a_en = 1'b1; a_up_dn = 1'b1; a_mode = 2'b00;
      a_start = 1'b0; a_load = 1'b0; a_load_val = '0; a_clr = 1'b0;
      b_ena = 1'b1; b_en = 1'b0; b_up_dn = 1'b1; b_mode = 2'b00;
      b_start = 1'b0; b_load = 1'b0; b_load_val = '0; b_clr = 1'b0;
      c_ena = 1'b1; c_en = 1'b0; c_up_dn = 1'b1; c_mode = 2'b01;
      c_start = 1'b0; c_load = 1'b0; c_load_val = '0; c_clr = 1'b0;
      d_ena = 1'b1; d_en = 1'b1; d_up_dn = 1'b1; d_mode = 2'b10;
      d_start = 1'b0; d_load = 1'b0; d_load_val = '0; d_clr = 1'b0;
      tick();
      tick();
      total++;
      if (a_count !== 3'd0 || a_tc !== 1'b0 || a_at_term !== 1'b0) begin
         bad++;
         $display("FAIL reset_a (ena=0) got count=%0d tc=%0b at_term=%0b exp 0/0/0",
                  a_count, a_tc, a_at_term);
      end
      total++;
      if (b_count !== 4'd0 || b_tc !== 1'b0 || c_count !== 4'd0 || c_tc !== 1'b0) begin
         bad++;
         $display("FAIL reset_bc got b=%0d/%0b c=%0d/%0b exp 0/0 0/0",
                  b_count, b_tc, c_count, c_tc);
      end
      total++;
      if (d_count !== 3'd0 || d_busy !== 1'b0 || d_tc !== 1'b0) begin
         bad++;
         $display("FAIL reset_d got count=%0d busy=%0b tc=%0b exp 0/0/0",
                  d_count, d_busy, d_tc);
      end
      rst_n = 1'b1; d_rst_n = 1'b1; a_ena = 1'b1;
   endtask

   task automatic test_legacy();
      int exp_c;
      for (int i = 0; i < 9; i++) begin
         tick();
         exp_c = (i + 1) % 8;
         total++;
         if (a_count !== exp_c || a_tc !== (i == 7) || a_at_term !== (exp_c == 7)) begin
            bad++;
            $display("FAIL legacy cyc=%0d got count=%0d tc=%0b at_term=%0b exp %0d/%0b/%0b",
                     i, a_count, a_tc, a_at_term, exp_c, (i == 7), (exp_c == 7));
         end
      end
   endtask

   task automatic test_modulus_prescale();
      int exp_c;
      b_en = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         tick();
         exp_c = (k / 3) % 10;
         total++;
         if (b_count !== exp_c || b_tc !== (k == 30)) begin
            bad++;
            $display("FAIL prescale cyc=%0d got count=%0d tc=%0b exp %0d/%0b",
                     k, b_count, b_tc, exp_c, (k == 30));
         end
      end
      b_ena = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         total++;
         if (b_count !== 4'd0) begin
            bad++;
            $display("FAIL freeze cyc=%0d got count=%0d exp 0", k, b_count);
         end
      end
      b_ena = 1'b1;
      for (int j = 1; j <= 30; j++) begin
         tick();
         exp_c = (j / 3) % 10;
         total++;
         if (b_count !== exp_c || b_tc !== (j == 30)) begin
            bad++;
            $display("FAIL prescale_resume cyc=%0d got count=%0d tc=%0b exp %0d/%0b",
                     j, b_count, b_tc, exp_c, (j == 30));
         end
      end
   endtask

   task automatic test_down_sat();
      int exp_c [5] = '{2, 1, 0, 0, 0};
      logic exp_t [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      c_en = 1'b1; c_up_dn = 1'b0; c_load = 1'b1; c_load_val = 4'd2;
      for (int i = 0; i < 5; i++) begin
         tick();
         c_load = 1'b0;
         total++;
         if (c_count !== exp_c[i] || c_tc !== exp_t[i]) begin
            bad++;
            $display("FAIL sat_down idx=%0d got count=%0d tc=%0b exp %0d/%0b",
                     i, c_count, c_tc, exp_c[i], exp_t[i]);
         end
      end
      total++;
      if (c_at_term !== 1'b1) begin
         bad++;
         $display("FAIL sat_at_term_down got %0b exp 1", c_at_term);
      end
      c_up_dn = 1'b1;
      #1;
      total++;
      if (c_at_term !== 1'b0) begin
         bad++;
         $display("FAIL sat_at_term_up got %0b exp 0", c_at_term);
      end
      for (int i = 1; i <= 3; i++) begin
         tick();
         total++;
         if (c_count !== i || c_tc !== 1'b0) begin
            bad++;
            $display("FAIL sat_up idx=%0d got count=%0d tc=%0b exp %0d/0",
                     i, c_count, c_tc, i);
         end
      end
   endtask

   task automatic test_priority();
      c_clr = 1'b1; c_load = 1'b1; c_load_val = 4'd7;
      tick();
      c_clr = 1'b0;
      total++;
      if (c_count !== 4'd0) begin
         bad++;
         $display("FAIL clr_over_load got count=%0d exp 0", c_count);
      end
      c_load_val = 4'd15;
      tick();
      c_load = 1'b0;
      total++;
      if (c_count !== 4'd9 || c_tc !== 1'b0) begin
         bad++;
         $display("FAIL load_clamp got count=%0d tc=%0b exp 9/0", c_count, c_tc);
      end
      tick();
      total++;
      if (c_count !== 4'd9 || c_tc !== 1'b0) begin
         bad++;
         $display("FAIL sat_hold_top got count=%0d tc=%0b exp 9/0", c_count, c_tc);
      end
      c_mode = 2'b10; c_start = 1'b1;
      tick();
      c_start = 1'b0;
      total++;
      if (c_count !== 4'd0 || c_busy !== 1'b1) begin
         bad++;
         $display("FAIL start_over_step got count=%0d busy=%0b exp 0/1", c_count, c_busy);
      end
      tick();
      c_mode = 2'b00;
      tick();
      c_mode = 2'b10;
      #1;
      total++;
      if (c_count !== 4'd2 || c_busy !== 1'b0) begin
         bad++;
         $display("FAIL mode_exit got count=%0d busy=%0b exp 2/0", c_count, c_busy);
      end
      tick();
      total++;
      if (c_count !== 4'd2 || c_busy !== 1'b0) begin
         bad++;
         $display("FAIL idle_hold got count=%0d busy=%0b exp 2/0", c_count, c_busy);
      end
   endtask

   task automatic test_oneshot();
      tick();
      total++;
      if (d_count !== 3'd0 || d_busy !== 1'b0) begin
         bad++;
         $display("FAIL os_idle got count=%0d busy=%0b exp 0/0", d_count, d_busy);
      end
      d_start = 1'b1;
      tick();
      d_start = 1'b0;
      total++;
      if (d_count !== 3'd0 || d_busy !== 1'b1) begin
         bad++;
         $display("FAIL os_arm got count=%0d busy=%0b exp 0/1", d_count, d_busy);
      end
      for (int i = 1; i <= 4; i++) begin
         tick();
         total++;
         if (d_count !== i || d_tc !== (i == 4) || d_busy !== (i < 4)) begin
            bad++;
            $display("FAIL os_run idx=%0d got count=%0d tc=%0b busy=%0b exp %0d/%0b/%0b",
                     i, d_count, d_tc, d_busy, i, (i == 4), (i < 4));
         end
      end
      for (int i = 0; i < 20; i++) begin
         tick();
         total++;
         if (d_count !== 3'd4 || d_tc !== 1'b0 || d_busy !== 1'b0 || d_at_term !== 1'b1) begin
            bad++;
            $display("FAIL os_done idx=%0d got count=%0d tc=%0b busy=%0b at_term=%0b exp 4/0/0/1",
                     i, d_count, d_tc, d_busy, d_at_term);
         end
      end
      d_start = 1'b1;
      tick();
      d_start = 1'b0;
      total++;
      if (d_count !== 3'd0 || d_busy !== 1'b1) begin
         bad++;
         $display("FAIL os_restart got count=%0d busy=%0b exp 0/1", d_count, d_busy);
      end
   endtask

   task automatic test_reset_mid_run();
      tick(); tick(); tick();
      total++;
      if (d_count !== 3'd3 || d_busy !== 1'b1) begin
         bad++;
         $display("FAIL mid_pre got count=%0d busy=%0b exp 3/1", d_count, d_busy);
      end
      d_rst_n = 1'b0;
      tick();
      total++;
      if (d_count !== 3'd0 || d_busy !== 1'b0 || d_tc !== 1'b0) begin
         bad++;
         $display("FAIL mid_reset got count=%0d busy=%0b tc=%0b exp 0/0/0",
                  d_count, d_busy, d_tc);
      end
      d_rst_n = 1'b1;
      tick();
      total++;
      if (d_count !== 3'd0 || d_busy !== 1'b0 || d_tc !== 1'b0) begin
         bad++;
         $display("FAIL mid_after got count=%0d busy=%0b tc=%0b exp 0/0/0",
                  d_count, d_busy, d_tc);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_legacy();
      test_modulus_prescale();
      test_down_sat();
      test_priority();
      test_oneshot();
      test_reset_mid_run();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
